vx_bundle_sched: RTL and testbench

Parametrised warp scheduler that issues multi-instruction fetch bundles. Each cycle it selects one ready warp, round-robin or fixed-priority. It emits that warp's PC, thread mask and a bundle instruction count, clipped so the bundle never crosses a fetch line. It sits between the warp-control/branch/decode feedback paths and the fetch stage, and replaces the single-instruction scheduler in multi-issue cores.

---
 rtl/vx_bundle_sched.sv | 209 ++++++++++++++++++++
 tb/tb_vx_bundle_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_bundle_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vx_bundle_sched: multi-instruction fetch-bundle warp scheduler.            |
// | Optional SCHED_PERF_EN adds 44-bit idle/stall performance counters.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vx_bundle_sched #(
   parameter int NUM_WARPS   = 4,
   parameter int NUM_THREADS = 4,
   parameter int XLEN        = 32,
   parameter int FETCH_WIDTH = 2,
   parameter int LINE_INSTRS = 4,
   parameter int RR_MODE     = 1
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [XLEN-1:0]                      startup_pc,
   input  logic                                 spawn_valid,
   input  logic [NUM_WARPS-1:0]                 spawn_wmask,
   input  logic [XLEN-1:0]                      spawn_pc,
   input  logic                                 tmc_valid,
   input  logic [$clog2(NUM_WARPS)-1:0]         tmc_wid,
   input  logic [NUM_THREADS-1:0]               tmc_tmask,
   input  logic                                 br_valid,
   input  logic [$clog2(NUM_WARPS)-1:0]         br_wid,
   input  logic                                 br_taken,
   input  logic [XLEN-1:0]                      br_dest,
   input  logic                                 unlock_valid,
   input  logic [$clog2(NUM_WARPS)-1:0]         unlock_wid,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [$clog2(NUM_WARPS)-1:0]         out_wid,
   output logic [XLEN-1:0]                      out_pc,
   output logic [NUM_THREADS-1:0]               out_tmask,
   output logic [$clog2(FETCH_WIDTH+1)-1:0]     out_count,
   output logic                                 busy,
   output logic [NUM_WARPS-1:0]                 active_warps
`ifdef SCHED_PERF_EN
   ,
   output logic [43:0]                          perf_idles,
   output logic [43:0]                          perf_stalls
`endif
);

   localparam int c_wid_w = $clog2(NUM_WARPS);
   localparam int c_cnt_w = $clog2(FETCH_WIDTH + 1);
   localparam logic [XLEN-1:0] c_line_mask = XLEN'(LINE_INSTRS - 1);
   localparam logic [XLEN-1:0] c_line_len  = XLEN'(LINE_INSTRS);
   localparam logic [XLEN-1:0] c_fetch_max = XLEN'(FETCH_WIDTH);

   logic [NUM_WARPS-1:0]   r_active;
   logic [NUM_WARPS-1:0]   r_stalled;
   logic [XLEN-1:0]        r_pc    [NUM_WARPS];
   logic [NUM_THREADS-1:0] r_tmask [NUM_WARPS];
   logic [c_wid_w-1:0]     r_rr_ptr;

   logic                   r_out_valid;
   logic [c_wid_w-1:0]     r_out_wid;
   logic [XLEN-1:0]        r_out_pc;
   logic [NUM_THREADS-1:0] r_out_tmask;
   logic [c_cnt_w-1:0]     r_out_count;
   logic                   r_busy;

   logic [NUM_WARPS-1:0]   w_ready;
   logic                   w_any_ready;
   logic [c_wid_w-1:0]     w_sel;
   logic [XLEN-1:0]        w_sel_pc;
   logic [XLEN-1:0]        w_room;
   logic [c_cnt_w-1:0]     w_count;
   logic [XLEN-1:0]        w_next_pc;
   logic                   w_load;

   assign w_ready     = r_active & ~r_stalled;
   assign w_any_ready = |w_ready;

   generate
      if (RR_MODE != 0) begin : g_rr_select
         always_comb begin
            logic                found;
            logic [c_wid_w-1:0]  idx;
            found = 1'b0;
            idx   = '0;
            w_sel = '0;
            // Index arithmetic wraps naturally because NUM_WARPS is a power of 2.
            for (int k = 0; k < NUM_WARPS; k++) begin
               idx = r_rr_ptr + c_wid_w'(k);
               if (!found && w_ready[idx]) begin
                  found = 1'b1;
                  w_sel = idx;
               end
            end
         end
      end else begin : g_fixed_select
         always_comb begin
            w_sel = '0;
            for (int k = NUM_WARPS - 1; k >= 0; k--) begin
               if (w_ready[k]) begin
                  w_sel = c_wid_w'(k);
               end
            end
         end
      end
   endgenerate

   // Bundle is clipped at the end of the fetch line holding the first instruction.
   assign w_sel_pc  = r_pc[w_sel];
   assign w_room    = c_line_len - ((w_sel_pc >> 2) & c_line_mask);
   assign w_count   = (w_room < c_fetch_max) ? c_cnt_w'(w_room) : c_cnt_w'(FETCH_WIDTH);
   assign w_next_pc = w_sel_pc + (XLEN'(w_count) << 2);
   assign w_load    = w_any_ready & (~r_out_valid | out_ready);

   // Per-warp state; later assignments take precedence within a cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_active  <= NUM_WARPS'(1);
         r_stalled <= '0;
         for (int i = 0; i < NUM_WARPS; i++) begin
            r_pc[i]    <= (i == 0) ? startup_pc : '0;
            r_tmask[i] <= (i == 0) ? NUM_THREADS'(1) : '0;
         end
      end else begin
         for (int i = 0; i < NUM_WARPS; i++) begin
            if (w_load && (w_sel == c_wid_w'(i))) begin
               r_pc[i] <= w_next_pc;
            end
            if (spawn_valid && spawn_wmask[i]) begin
               r_active[i] <= 1'b1;
               r_tmask[i]  <= NUM_THREADS'(1);
               r_pc[i]     <= spawn_pc;
            end
            if (tmc_valid && (tmc_wid == c_wid_w'(i))) begin
               r_active[i]  <= |tmc_tmask;
               r_tmask[i]   <= tmc_tmask;
               r_stalled[i] <= 1'b0;
            end
            if (br_valid && (br_wid == c_wid_w'(i))) begin
               if (br_taken) begin
                  r_pc[i] <= br_dest;
               end
               r_stalled[i] <= 1'b0;
            end
            if (unlock_valid && (unlock_wid == c_wid_w'(i))) begin
               r_stalled[i] <= 1'b0;
            end
            if (w_load && (w_sel == c_wid_w'(i))) begin
               r_stalled[i] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_wid   <= '0;
         r_out_pc    <= '0;
         r_out_tmask <= '0;
         r_out_count <= '0;
         r_rr_ptr    <= '0;
         r_busy      <= 1'b0;
      end else begin
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_wid   <= w_sel;
            r_out_pc    <= w_sel_pc;
            r_out_tmask <= r_tmask[w_sel];
            r_out_count <= w_count;
            if (RR_MODE != 0) begin
               r_rr_ptr <= w_sel + c_wid_w'(1);
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
         r_busy <= (|r_active) | r_out_valid;
      end
   end

`ifdef SCHED_PERF_EN
   logic [43:0] r_perf_idles;
   logic [43:0] r_perf_stalls;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_perf_idles  <= '0;
         r_perf_stalls <= '0;
      end else begin
         if (!w_any_ready) begin
            r_perf_idles <= r_perf_idles + 44'd1;
         end
         if (r_out_valid && !out_ready) begin
            r_perf_stalls <= r_perf_stalls + 44'd1;
         end
      end
   end

   assign perf_idles  = r_perf_idles;
   assign perf_stalls = r_perf_stalls;
`endif

   assign out_valid    = r_out_valid;
   assign out_wid      = r_out_wid;
   assign out_pc       = r_out_pc;
   assign out_tmask    = r_out_tmask;
   assign out_count    = r_out_count;
   assign busy         = r_busy;
   assign active_warps = r_active;

endmodule
`default_nettype wire

// File: tb/tb_vx_bundle_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vx_bundle_sched: directed bench for vx_bundle_sched (RR, FW=2 instance  |
// | plus a fixed-priority FW=4 instance). Revision: 1.0                        |
// +----------------------------------------------------------------------------+
module tb_vx_bundle_sched;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] startup_pc;
   logic        spawn_valid;
   logic [3:0]  spawn_wmask;
   logic [31:0] spawn_pc;
   logic        tmc_valid;
   logic [1:0]  tmc_wid;
   logic [3:0]  tmc_tmask;
   logic        br_valid;
   logic [1:0]  br_wid;
   logic        br_taken;
   logic [31:0] br_dest;
   logic        unlock_valid;
   logic [1:0]  unlock_wid;
   logic        out_ready;
   logic        out_valid;
   logic [1:0]  out_wid;
   logic [31:0] out_pc;
   logic [3:0]  out_tmask;
   logic [1:0]  out_count;
   logic        busy;
   logic [3:0]  active_warps;

   logic [31:0] b_startup_pc;
   logic        b_unlock_valid;
   logic [1:0]  b_unlock_wid;
   logic        b_out_valid;
   logic [1:0]  b_out_wid;
   logic [31:0] b_out_pc;
   logic [3:0]  b_out_tmask;
   logic [2:0]  b_out_count;
   logic        b_busy;
   logic [3:0]  b_active_warps;

`ifdef SCHED_PERF_EN
   logic [43:0] perf_idles, perf_stalls, b_perf_idles, b_perf_stalls, stalls_base;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vx_bundle_sched #(
      .NUM_WARPS(4), .NUM_THREADS(4), .XLEN(32),
      .FETCH_WIDTH(2), .LINE_INSTRS(4), .RR_MODE(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .startup_pc(startup_pc),
      .spawn_valid(spawn_valid), .spawn_wmask(spawn_wmask), .spawn_pc(spawn_pc),
      .tmc_valid(tmc_valid), .tmc_wid(tmc_wid), .tmc_tmask(tmc_tmask),
      .br_valid(br_valid), .br_wid(br_wid), .br_taken(br_taken), .br_dest(br_dest),
      .unlock_valid(unlock_valid), .unlock_wid(unlock_wid),
      .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid),
      .out_pc(out_pc), .out_tmask(out_tmask), .out_count(out_count),
      .busy(busy), .active_warps(active_warps)
`ifdef SCHED_PERF_EN
      , .perf_idles(perf_idles), .perf_stalls(perf_stalls)
`endif
   );

   vx_bundle_sched #(
      .NUM_WARPS(4), .NUM_THREADS(4), .XLEN(32),
      .FETCH_WIDTH(4), .LINE_INSTRS(4), .RR_MODE(0)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .startup_pc(b_startup_pc),
      .spawn_valid(spawn_valid), .spawn_wmask(spawn_wmask), .spawn_pc(spawn_pc),
      .tmc_valid(1'b0), .tmc_wid(2'd0), .tmc_tmask(4'd0),
      .br_valid(1'b0), .br_wid(2'd0), .br_taken(1'b0), .br_dest(32'd0),
      .unlock_valid(b_unlock_valid), .unlock_wid(b_unlock_wid),
      .out_valid(b_out_valid), .out_ready(1'b1), .out_wid(b_out_wid),
      .out_pc(b_out_pc), .out_tmask(b_out_tmask), .out_count(b_out_count),
      .busy(b_busy), .active_warps(b_active_warps)
`ifdef SCHED_PERF_EN
      , .perf_idles(b_perf_idles), .perf_stalls(b_perf_stalls)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [1:0] wid, input logic [31:0] pc,
                        input logic [1:0] cnt);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_wid"},   64'(out_wid),   64'(wid));
      chk({tag, "_pc"},    64'(out_pc),    64'(pc));
      chk({tag, "_count"}, 64'(out_count), 64'(cnt));
   endtask

   task automatic chk_b(input string tag, input logic [1:0] wid, input logic [31:0] pc,
                        input logic [2:0] cnt);
      chk({tag, "_valid"}, 64'(b_out_valid), 64'd1);
      chk({tag, "_wid"},   64'(b_out_wid),   64'(wid));
      chk({tag, "_pc"},    64'(b_out_pc),    64'(pc));
      chk({tag, "_count"}, 64'(b_out_count), 64'(cnt));
   endtask

   initial begin
      reset_n = 1'b0;      startup_pc = 32'h8000_0008; b_startup_pc = 32'h8000_000C;
      spawn_valid = 1'b0;  spawn_wmask = '0;  spawn_pc = '0;
      tmc_valid = 1'b0;    tmc_wid = '0;      tmc_tmask = '0;
      br_valid = 1'b0;     br_wid = '0;       br_taken = 1'b0;  br_dest = '0;
      unlock_valid = 1'b0; unlock_wid = '0;   out_ready = 1'b1;
      b_unlock_valid = 1'b0; b_unlock_wid = '0;

      repeat (2) tick();
      chk("rst_valid",  64'(out_valid),    64'd0);
      chk("rst_pc",     64'(out_pc),       64'd0);
      chk("rst_count",  64'(out_count),    64'd0);
      chk("rst_tmask",  64'(out_tmask),    64'd0);
      chk("rst_active", 64'(active_warps), 64'h1);

      // First bundle straight after reset release.
      reset_n = 1'b1;
      tick();
      chk_a("first", 2'd0, 32'h8000_0008, 2'd2);
      chk("first_tmask", 64'(out_tmask), 64'h1);
      chk_b("b_first", 2'd0, 32'h8000_000C, 3'd1);

      unlock_valid = 1'b1; unlock_wid = 2'd0;
      b_unlock_valid = 1'b1; b_unlock_wid = 2'd0;
      tick();
      chk("drain_valid", 64'(out_valid), 64'd0);
      unlock_valid = 1'b0; b_unlock_valid = 1'b0;
      tick();
      chk_a("second", 2'd0, 32'h8000_0010, 2'd2);
      chk_b("b_second", 2'd0, 32'h8000_0010, 3'd4);
      chk("busy_on", 64'(busy), 64'd1);

      // Back-pressure: five cycles with out_ready low.
`ifdef SCHED_PERF_EN
      stalls_base = perf_stalls;
`endif
      unlock_valid = 1'b1; unlock_wid = 2'd0; out_ready = 1'b0;
      tick();
      unlock_valid = 1'b0;
      chk("hold1_pc", 64'(out_pc), 64'h8000_0010);
      for (int n = 0; n < 4; n++) begin
         tick();
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_pc",    64'(out_pc),    64'h8000_0010);
      end
`ifdef SCHED_PERF_EN
      chk("perf_stalls", 64'(perf_stalls - stalls_base), 64'd5);
`endif
      out_ready = 1'b1;
      tick();
      chk_a("after_hold", 2'd0, 32'h8000_0018, 2'd2);

      // Spawn warps 1..3; round-robin issue with per-cycle unlocks.
      spawn_valid = 1'b1; spawn_wmask = 4'b1110; spawn_pc = 32'h100;
      unlock_valid = 1'b1; unlock_wid = 2'd0;
      b_unlock_valid = 1'b1; b_unlock_wid = 2'd0;
      tick();
      spawn_valid = 1'b0; unlock_valid = 1'b0;
      chk("spawn_valid",  64'(out_valid),    64'd0);
      chk("spawn_active", 64'(active_warps), 64'hF);
      tick();
      chk_a("rr_w1", 2'd1, 32'h100, 2'd2);
      chk_b("b_fix0", 2'd0, 32'h8000_0020, 3'd4);
      unlock_valid = 1'b1; unlock_wid = 2'd1;
      tick();
      chk_a("rr_w2", 2'd2, 32'h100, 2'd2);
      chk("b_fix1_wid", 64'(b_out_wid), 64'd1);
      unlock_wid = 2'd2;
      tick();
      chk_a("rr_w3", 2'd3, 32'h100, 2'd2);
      chk_b("b_fix0_again", 2'd0, 32'h8000_0030, 3'd4);
      unlock_wid = 2'd3; b_unlock_valid = 1'b0;
      tick();
      chk_a("rr_w0", 2'd0, 32'h8000_0020, 2'd2);
      unlock_wid = 2'd0;
      tick();
      chk_a("rr_w1b", 2'd1, 32'h108, 2'd2);
      unlock_valid = 1'b0;
      tick();
      chk_a("rr_w2b", 2'd2, 32'h108, 2'd2);
      tick();
      tick();
      chk_a("rr_w0b", 2'd0, 32'h8000_0028, 2'd2);

      // Respawn warp 1 at 0x100, then branch to 0x200 as it is loaded.
      spawn_valid = 1'b1; spawn_wmask = 4'b0010; spawn_pc = 32'h100;
      unlock_valid = 1'b1; unlock_wid = 2'd1;
      tick();
      spawn_valid = 1'b0; unlock_valid = 1'b0;
      chk("idle_valid", 64'(out_valid), 64'd0);
      br_valid = 1'b1; br_wid = 2'd1; br_taken = 1'b1; br_dest = 32'h200;
      tick();
      br_valid = 1'b0;
      chk_a("br_load", 2'd1, 32'h100, 2'd2);
      tick();
      chk("br_stall1", 64'(out_valid), 64'd0);
      tick();
      chk("br_stall2", 64'(out_valid), 64'd0);
      unlock_valid = 1'b1; unlock_wid = 2'd1;
      tick();
      unlock_valid = 1'b0;
      tick();
      chk_a("br_target", 2'd1, 32'h200, 2'd2);

      // Deactivate every warp via thread-mask changes.
      tmc_valid = 1'b1; tmc_tmask = 4'b0000;
      for (int w = 0; w < 4; w++) begin
         tmc_wid = 2'(w);
         tick();
      end
      tmc_valid = 1'b0;
      chk("tmc_active", 64'(active_warps), 64'h0);
      chk("tmc_valid",  64'(out_valid),    64'd0);
      chk("busy_late",  64'(busy),         64'd1);
      tick();
      chk("busy_off",   64'(busy),         64'd0);

      // Reactivate warp 2 with a multi-thread mask.
      tmc_valid = 1'b1; tmc_wid = 2'd2; tmc_tmask = 4'b1011;
      tick();
      tmc_valid = 1'b0;
      chk("tmc2_active", 64'(active_warps), 64'h4);
      tick();
      chk_a("tmc2_load", 2'd2, 32'h110, 2'd2);
      chk("tmc2_tmask", 64'(out_tmask), 64'hB);

      // Reset mid-operation, with a startup PC one slot before the line end.
      startup_pc = 32'h8000_000C;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid",  64'(out_valid),    64'd0);
      chk("mid_rst_active", 64'(active_warps), 64'h1);
      tick();
      reset_n = 1'b1;
      tick();
      chk_a("rst_first", 2'd0, 32'h8000_000C, 2'd1);
      chk_b("b_rst_first", 2'd0, 32'h8000_000C, 3'd1);
      unlock_valid = 1'b1; unlock_wid = 2'd0;
      tick();
      unlock_valid = 1'b0;
      tick();
      chk_a("rst_second", 2'd0, 32'h8000_0010, 2'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
